// File: rtl/rf_serial_seq.sv
// Sequencer that runs one register-to-register op through a 1-bit serial ALU:
// it reads both sources, streams them LSB-first for WIDTH cycles, then writes rd.
`default_nettype none

module rf_serial_seq #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_rs1,
    input  logic [AW-1:0]    req_rs2,
    input  logic [AW-1:0]    req_rd,
    input  logic             flush,
    output logic [AW-1:0]    rf_rs1,
    output logic [AW-1:0]    rf_rs2,
    input  logic [WIDTH-1:0] rf_rs1_data,
    input  logic [WIDTH-1:0] rf_rs2_data,
    output logic [AW-1:0]    rf_rd,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             alu_first,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_res,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SHIFT,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [AW-1:0]     rs1_q, rs1_d;
    logic [AW-1:0]     rs2_q, rs2_d;
    logic [AW-1:0]     rd_q, rd_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    // rf_rd is held at 0 outside WB so the reg_file never forwards on a stale match.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        req_ready = 1'b0;
        rf_rs1    = '0;
        rf_rs2    = '0;
        rf_rd     = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        alu_first = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    rd_d    = req_rd;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rf_rs1 = rs1_q;
                rf_rs2 = rs2_q;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d     = rf_rs1_data;
                    b_d     = rf_rs2_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                alu_a     = a_q[0];
                alu_b     = b_q[0];
                alu_first = (cnt_q == '0);
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {alu_res, res_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_rd    = rd_q;
                rf_wdata = res_q;
                if (!flush) begin
                    rf_we = (rd_q != '0);
                    done  = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_serial_seq.sv
// Directed bench for rf_serial_seq with a behavioural reg_file and serial adder.
`timescale 1ns/1ps

module tb_rf_serial_seq;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_rs1, req_rs2, req_rd;
    logic             flush;
    logic [AW-1:0]    rf_rs1, rf_rs2, rf_rd;
    logic [WIDTH-1:0] rf_rs1_data, rf_rs2_data;
    logic             rf_we;
    logic [WIDTH-1:0] rf_wdata;
    logic             alu_first, alu_a, alu_b, alu_res;
    logic             done;

    always #5 clk = ~clk;

    rf_serial_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .alu_first(alu_first), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .done(done)
    );

    // Register file model: reg 0 reads zero; bench preload port has priority.
    logic [WIDTH-1:0] regs [0:(1<<AW)-1];
    logic             pre_we;
    logic [AW-1:0]    pre_addr;
    logic [WIDTH-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (rf_we) regs[rf_rd] <= rf_wdata;
    end
    assign rf_rs1_data = (rf_rs1 == '0) ? '0 : regs[rf_rs1];
    assign rf_rs2_data = (rf_rs2 == '0) ? '0 : regs[rf_rs2];

    // Serial ripple adder: carry cleared on the first bit of each op.
    logic carry_q = 1'b0;
    logic cin;
    assign cin     = alu_first ? 1'b0 : carry_q;
    assign alu_res = alu_a ^ alu_b ^ cin;
    always @(posedge clk) carry_q <= (alu_a & alu_b) | (alu_a & cin) | (alu_b & cin);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] v);
        if (a != '0) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = a; pre_data = v;
            @(negedge clk);
            pre_we = 1'b0;
        end
    endtask

    // Issue one request; cycle 1 is the cycle after the accept edge.
    task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, output int done_cyc,
                          output logic we_seen, output logic [WIDTH-1:0] wd,
                          output logic leak);
        done_cyc = -1; we_seen = 1'b0; wd = '0; leak = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_rs1 = 3'd7; req_rs2 = 3'd6; req_rd = 3'd5;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (rf_we) we_seen = 1'b1;
            if (!done && rf_rd != '0) leak = 1'b1;
            if (done) begin
                done_cyc = cyc;
                wd = rf_wdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [AW-1:0]    pa;  logic [WIDTH-1:0] pva;
        logic [AW-1:0]    pb;  logic [WIDTH-1:0] pvb;
        logic [AW-1:0]    rs1, rs2, rd;
        logic [WIDTH-1:0] exp_wdata;
        logic             exp_we;
        logic [AW-1:0]    chk_addr;
        logic [WIDTH-1:0] chk_val;
    } vec_t;

    vec_t vecs [6];

    int               dcyc;
    logic             wes, lk;
    logic [WIDTH-1:0] wdv;
    int               done_at [$];
    int               ready_bad;
    logic             flag;

    initial begin
        vecs[0] = '{3'd1, 16'h1234, 3'd2, 16'h0F0F, 3'd1, 3'd2, 3'd3, 16'h2143, 1'b1, 3'd3, 16'h2143};
        vecs[1] = '{3'd1, 16'h1234, 3'd2, 16'h0F0F, 3'd1, 3'd2, 3'd0, 16'h2143, 1'b0, 3'd3, 16'h2143};
        vecs[2] = '{3'd4, 16'h8001, 3'd0, 16'h0000, 3'd4, 3'd4, 3'd4, 16'h0002, 1'b1, 3'd4, 16'h0002};
        vecs[3] = '{3'd5, 16'hFFFF, 3'd6, 16'h0001, 3'd0, 3'd5, 3'd6, 16'hFFFF, 1'b1, 3'd6, 16'hFFFF};
        vecs[4] = '{3'd7, 16'hFFFF, 3'd6, 16'h0001, 3'd7, 3'd6, 3'd7, 16'h0000, 1'b1, 3'd7, 16'h0000};
        vecs[5] = '{3'd1, 16'h00FF, 3'd2, 16'h0101, 3'd1, 3'd2, 3'd5, 16'h0200, 1'b1, 3'd5, 16'h0200};

        rst = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        flush = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset rf_we", 32'(rf_we), 0);
        chk("reset done", 32'(done), 0);
        chk("reset rf_rd", 32'(rf_rd), 0);
        chk("reset alu_first", 32'(alu_first), 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].pa, vecs[i].pva);
            preload(vecs[i].pb, vecs[i].pvb);
            run_op(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, dcyc, wes, wdv, lk);
            chk($sformatf("v%0d done cycle", i), 32'(dcyc), 18);
            chk($sformatf("v%0d rf_we", i), 32'(wes), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d rf_wdata", i), 32'(wdv), 32'(vecs[i].exp_wdata));
            chk($sformatf("v%0d rf_rd leak", i), 32'(lk), 0);
            @(negedge clk);
            chk($sformatf("v%0d reg check", i), 32'(regs[vecs[i].chk_addr]), 32'(vecs[i].chk_val));
        end

        // Flush in SHIFT at cycle 10: no writeback, ready again at cycle 11.
        preload(3'd1, 16'h1234); preload(3'd2, 16'h0F0F); preload(3'd3, 16'h5555);
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        chk("flush cycle done", 32'(done), 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush ready at 11", 32'(req_ready), 1);
        flag = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done || rf_we) flag = 1'b1;
            @(negedge clk);
        end
        chk("flush no done/we", 32'(flag), 0);
        chk("flush R3 kept", 32'(regs[3]), 32'h5555);

        // Reset at cycle 5 mid-op, then a normal op.
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 1);
        chk("rst alu_a/b/first", 32'({alu_a, alu_b, alu_first}), 0);
        chk("rst rf_rs1", 32'(rf_rs1), 0);
        rst = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done || rf_we) flag = 1'b1;
            @(negedge clk);
        end
        chk("rst no done/we", 32'(flag), 0);
        chk("rst R3 kept", 32'(regs[3]), 32'h5555);
        run_op(3'd1, 3'd2, 3'd3, dcyc, wes, wdv, lk);
        chk("post-rst done cycle", 32'(dcyc), 18);
        @(negedge clk);
        chk("post-rst R3", 32'(regs[3]), 32'h2143);

        // Back-to-back with req_valid held high.
        preload(3'd3, 16'h0000);
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd3;
        ready_bad = 0;
        chk("b2b ready at 0", 32'(req_ready), 1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) done_at.push_back(cyc);
            if (((cyc >= 1 && cyc <= 18) || (cyc >= 20 && cyc <= 37)) && req_ready) ready_bad++;
            if (cyc == 19 && !req_ready) ready_bad++;
            if (cyc == 37) req_valid = 1'b0;
        end
        chk("b2b done count", 32'(done_at.size()), 2);
        if (done_at.size() == 2) begin
            chk("b2b done 1st", 32'(done_at[0]), 18);
            chk("b2b done 2nd", 32'(done_at[1]), 37);
        end
        chk("b2b ready pattern", 32'(ready_bad), 0);
        chk("b2b R3", 32'(regs[3]), 32'h2143);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
